// File: rtl/core_alu_arbiter.sv
// Shares one combinational ALU between execute (port 0) and branch/AGU (port 1).
// Round-robin by default; define CORE_ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module core_alu_arbiter #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ0_VALID,
  output logic            REQ0_READY,
  input  logic [OPW-1:0]  REQ0_OP,
  input  logic [XLEN-1:0] REQ0_I1,
  input  logic [XLEN-1:0] REQ0_I2,
  output logic            RSP0_VALID,
  input  logic            RSP0_READY,
  input  logic            REQ1_VALID,
  output logic            REQ1_READY,
  input  logic [OPW-1:0]  REQ1_OP,
  input  logic [XLEN-1:0] REQ1_I1,
  input  logic [XLEN-1:0] REQ1_I2,
  output logic            RSP1_VALID,
  input  logic            RSP1_READY,
  output logic [XLEN-1:0] RSP_DATA,
  output logic [OPW-1:0]  ALU_OPCODE,
  output logic [XLEN-1:0] ALU_I1,
  output logic [XLEN-1:0] ALU_I2,
  input  logic [XLEN-1:0] ALU_O,
  output logic            BUSY
);

  localparam logic [OPW-1:0] ALU_CODE_ADD = '0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_gnt;
  logic [OPW-1:0]  r_alu_op;
  logic [XLEN-1:0] r_alu_i1;
  logic [XLEN-1:0] r_alu_i2;
  logic [XLEN-1:0] r_rsp_data;

  logic            w_winner;
  logic            w_idle;
  logic            w_rdy0;
  logic            w_rdy1;
  logic            w_hs;
  logic            w_rsp_take;

`ifdef CORE_ALU_ARB_FIXED_PRIO_EN
  // Port 1 only wins when port 0 has nothing pending.
  always_comb w_winner = ~REQ0_VALID;
`else
  logic r_last;

  always_comb begin
    w_winner = 1'b0;
    if (REQ0_VALID && REQ1_VALID) begin
      w_winner = ~r_last;
    end else if (REQ1_VALID) begin
      w_winner = 1'b1;
    end
  end

  // LAST resets to 1 so port 0 takes the first tie.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_last <= 1'b1;
    end else if (w_rsp_take) begin
      r_last <= r_gnt;
    end
  end
`endif

  // READY is gated by RST so nothing is accepted while reset is asserted.
  assign w_idle     = (r_state == IDLE) && !RST;
  assign w_rdy0     = w_idle && REQ0_VALID && !w_winner;
  assign w_rdy1     = w_idle && REQ1_VALID &&  w_winner;
  assign w_hs       = w_rdy0 || w_rdy1;
  assign w_rsp_take = (r_state == RESP) && (r_gnt ? RSP1_READY : RSP0_READY);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_rsp_take) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture on the request handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_gnt    <= 1'b0;
      r_alu_op <= ALU_CODE_ADD;
      r_alu_i1 <= '0;
      r_alu_i2 <= '0;
    end else if (w_hs) begin
      r_gnt    <= w_rdy1;
      r_alu_op <= w_rdy1 ? REQ1_OP : REQ0_OP;
      r_alu_i1 <= w_rdy1 ? REQ1_I1 : REQ0_I1;
      r_alu_i2 <= w_rdy1 ? REQ1_I2 : REQ0_I2;
    end
  end

  // Result capture after the single EXEC cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rsp_data <= '0;
    end else if (r_state == EXEC) begin
      r_rsp_data <= ALU_O;
    end
  end

  assign REQ0_READY = w_rdy0;
  assign REQ1_READY = w_rdy1;
  assign RSP0_VALID = (r_state == RESP) && !r_gnt;
  assign RSP1_VALID = (r_state == RESP) &&  r_gnt;
  assign RSP_DATA   = r_rsp_data;
  assign ALU_OPCODE = r_alu_op;
  assign ALU_I1     = r_alu_i1;
  assign ALU_I2     = r_alu_i2;
  assign BUSY       = (r_state != IDLE);

endmodule

// File: tb/tb_core_alu_arbiter.sv
// Scoreboard bench for core_alu_arbiter with a behavioural ALU and arbitration model.
module tb_core_alu_arbiter;

  localparam logic [3:0] C_ADD  = 4'h0;
  localparam logic [3:0] C_SUB  = 4'h1;
  localparam logic [3:0] C_SLL  = 4'h2;
  localparam logic [3:0] C_SRL  = 4'h3;
  localparam logic [3:0] C_SRA  = 4'h4;
  localparam logic [3:0] C_AND  = 4'h5;
  localparam logic [3:0] C_OR   = 4'h6;
  localparam logic [3:0] C_XOR  = 4'h7;
  localparam logic [3:0] C_SLT  = 4'h8;
  localparam logic [3:0] C_SLTU = 4'h9;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic        REQ0_READY, REQ1_READY;
  logic [3:0]  REQ0_OP = '0, REQ1_OP = '0;
  logic [31:0] REQ0_I1 = '0, REQ0_I2 = '0, REQ1_I1 = '0, REQ1_I2 = '0;
  logic        RSP0_VALID, RSP1_VALID;
  logic        RSP0_READY = 1'b0, RSP1_READY = 1'b0;
  logic [31:0] RSP_DATA;
  logic [3:0]  ALU_OPCODE;
  logic [31:0] ALU_I1, ALU_I2, ALU_O;
  logic        BUSY;

  int n_chk = 0;
  int n_err = 0;
  int rdy_prob = 100;

  typedef struct packed {
    logic        p;
    logic [31:0] d;
  } sb_t;
  sb_t sb_q[$];

  core_alu_arbiter #(.XLEN(32), .OPW(4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OP(REQ0_OP),
    .REQ0_I1(REQ0_I1), .REQ0_I2(REQ0_I2), .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OP(REQ1_OP),
    .REQ1_I1(REQ1_I1), .REQ1_I2(REQ1_I2), .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY),
    .RSP_DATA(RSP_DATA), .ALU_OPCODE(ALU_OPCODE), .ALU_I1(ALU_I1), .ALU_I2(ALU_I2),
    .ALU_O(ALU_O), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      C_ADD:   return a + b;
      C_SUB:   return a - b;
      C_SLL:   return a << b[4:0];
      C_SRL:   return a >> b[4:0];
      C_SRA:   return $signed(a) >>> b[4:0];
      C_AND:   return a & b;
      C_OR:    return a | b;
      C_XOR:   return a ^ b;
      C_SLT:   return {31'd0, $signed(a) < $signed(b)};
      C_SLTU:  return {31'd0, a < b};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // The ALU instance the arbiter feeds.
  always_comb ALU_O = ref_alu(ALU_OPCODE, ALU_I1, ALU_I2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issues one request on port p and returns just after its handshake edge.
  task automatic drive(input int p, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int gap);
    logic hs;
    int   n;
    repeat (gap) @(posedge CLK);
    #1;
    if (p == 0) begin
      REQ0_VALID = 1'b1; REQ0_OP = op; REQ0_I1 = a; REQ0_I2 = b;
    end else begin
      REQ1_VALID = 1'b1; REQ1_OP = op; REQ1_I1 = a; REQ1_I2 = b;
    end
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 2000) begin
      @(negedge CLK);
      hs = (p == 0) ? REQ0_READY : REQ1_READY;
      n++;
    end
    check(p == 0 ? "req0_timeout" : "req1_timeout", {31'd0, hs}, 32'd1);
    @(posedge CLK);
    #1;
    if (p == 0) REQ0_VALID = 1'b0;
    else        REQ1_VALID = 1'b0;
  endtask

  // Response-side backpressure.
  initial forever begin
    @(posedge CLK);
    #1;
    RSP0_READY = (int'($urandom_range(0, 99)) < rdy_prob);
    RSP1_READY = (int'($urandom_range(0, 99)) < rdy_prob);
  end

  // Reference model: owner of the ALU, cycles since grant, last served port.
  initial begin
    int   m_owner;
    int   m_age;
    logic m_last;
    logic w, eb, er0, er1, erv0, erv1;
    m_owner = -1;
    m_age   = 0;
    m_last  = 1'b1;
    forever begin
      @(negedge CLK);
      if (RST) begin
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_ready0", {31'd0, REQ0_READY}, 32'd0);
        check("rst_ready1", {31'd0, REQ1_READY}, 32'd0);
        check("rst_rspv0", {31'd0, RSP0_VALID}, 32'd0);
        check("rst_rspv1", {31'd0, RSP1_VALID}, 32'd0);
        m_owner = -1;
        m_last  = 1'b1;
        sb_q.delete();
      end else begin
        if (m_owner >= 0) m_age++;
        eb   = (m_owner >= 0);
        erv0 = (m_owner == 0) && (m_age >= 2);
        erv1 = (m_owner == 1) && (m_age >= 2);
`ifdef CORE_ALU_ARB_FIXED_PRIO_EN
        w = !REQ0_VALID;
`else
        if (REQ0_VALID && REQ1_VALID) w = !m_last;
        else                          w = REQ1_VALID;
`endif
        er0 = !eb && REQ0_VALID && !w;
        er1 = !eb && REQ1_VALID &&  w;
        check("busy", {31'd0, BUSY}, {31'd0, eb});
        check("ready0", {31'd0, REQ0_READY}, {31'd0, er0});
        check("ready1", {31'd0, REQ1_READY}, {31'd0, er1});
        check("rspv0", {31'd0, RSP0_VALID}, {31'd0, erv0});
        check("rspv1", {31'd0, RSP1_VALID}, {31'd0, erv1});
        if (er0) begin
          sb_q.push_back('{p: 1'b0, d: ref_alu(REQ0_OP, REQ0_I1, REQ0_I2)});
          m_owner = 0; m_age = 0;
        end else if (er1) begin
          sb_q.push_back('{p: 1'b1, d: ref_alu(REQ1_OP, REQ1_I1, REQ1_I2)});
          m_owner = 1; m_age = 0;
        end else if ((erv0 && RSP0_READY) || (erv1 && RSP1_READY)) begin
          m_last  = (m_owner == 1);
          m_owner = -1;
        end
      end
    end
  end

  // Response monitor: compares every presented response against the queue head.
  initial forever begin
    @(negedge CLK);
    if (!RST && (RSP0_VALID || RSP1_VALID)) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", {30'd0, RSP1_VALID, RSP0_VALID}, 32'd0);
      end else begin
        check("rsp_port", {31'd0, RSP1_VALID}, {31'd0, sb_q[0].p});
        check("rsp_data", RSP_DATA, sb_q[0].d);
        if (RSP1_VALID ? RSP1_READY : RSP0_READY) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #1 RST = 1'b1;
    REQ0_VALID = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_opcode", {28'd0, ALU_OPCODE}, {28'd0, C_ADD});
    check("reset_rsp_data", RSP_DATA, 32'd0);
    check("reset_i1", ALU_I1, 32'd0);
    check("reset_i2", ALU_I2, 32'd0);
    check("reset_ready0", {31'd0, REQ0_READY}, 32'd0);
    REQ0_VALID = 1'b0;
    RST = 1'b0;
    repeat (2) @(posedge CLK);

    drive(0, C_ADD, 32'd5, 32'd7, 0);
    repeat (4) @(posedge CLK);

    fork
      drive(0, C_SUB, 32'd10, 32'd3, 0);
      drive(1, C_SLL, 32'd1, 32'd4, 0);
    join
    repeat (4) @(posedge CLK);
    fork
      drive(0, C_OR, 32'hF0, 32'h0F, 0);
      drive(1, C_SLT, 32'hFFFF_FFFF, 32'd1, 0);
    join
    repeat (4) @(posedge CLK);

    rdy_prob = 0;
    fork
      drive(1, C_SRA, 32'h8000_0000, 32'd4, 0);
      drive(0, C_ADD, 32'd1, 32'd2, 1);
      begin repeat (8) @(posedge CLK); rdy_prob = 100; end
    join
    repeat (4) @(posedge CLK);

    drive(0, C_XOR, 32'h1234, 32'hFF, 0);
    REQ0_VALID = 1'b1;
    RST = 1'b1;
    #1;
    check("midrst_busy", {31'd0, BUSY}, 32'd0);
    check("midrst_ready0", {31'd0, REQ0_READY}, 32'd0);
    check("midrst_rspv0", {31'd0, RSP0_VALID}, 32'd0);
    check("midrst_opcode", {28'd0, ALU_OPCODE}, {28'd0, C_ADD});
    check("midrst_rsp_data", RSP_DATA, 32'd0);
    @(posedge CLK);
    #1 REQ0_VALID = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (5) @(posedge CLK);

    drive(1, 4'hF, 32'h1357, 32'h2468, 0);
    drive(0, C_SUB, 32'd3, 32'd5, 0);
    repeat (4) @(posedge CLK);

    fork
      repeat (3) drive(0, C_ADD, $urandom, $urandom, 0);
      repeat (3) drive(1, C_AND, $urandom, $urandom, 0);
    join

    rdy_prob = 70;
    fork
      repeat (40) drive(0, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 3));
      repeat (40) drive(1, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 3));
    join
    rdy_prob = 100;
    repeat (10) @(posedge CLK);
    #1;
    check("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
